// File: rtl/turf_register_bank.sv
`default_nettype none
// ============================================================================
// Module  : turf_register_bank
// Brief   : Decoded 256-word register space (ident, scratch, access counter,
//           control and sticky status registers) behind an en/wr/ack bus.
// Revision: 1.0 - initial release
// ============================================================================
module turf_register_bank #(
    parameter int                        NUM_CTRL       = 4,
    parameter int                        NUM_STAT       = 4,
    parameter int                        ADR_WIDTH      = 28,
    parameter logic [31:0]               IDENT          = 32'h0,
    parameter logic [31:0]               DATEVERSION    = 32'h0,
    parameter logic [32*NUM_CTRL-1:0]    CTRL_RESET     = '0,
    parameter logic [32*NUM_CTRL-1:0]    PULSE_MASK     = '0,
    parameter logic [32*NUM_STAT-1:0]    STICKY_MASK    = '0,
    parameter logic [31:0]               UNMAPPED_VALUE = 32'hBAADF00D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     wr_i,
    output logic                     ack_o,
    input  logic [ADR_WIDTH-1:0]     adr_i,
    input  logic [31:0]              dat_i,
    output logic [31:0]              dat_o,
    output logic [32*NUM_CTRL-1:0]   ctrl_o,
    output logic [NUM_CTRL-1:0]      ctrl_wr_o,
    input  logic [32*NUM_STAT-1:0]   stat_i
);

    logic                   ack_q,     ack_d;
    logic [31:0]            dat_q,     dat_d;
    logic [31:0]            cnt_q,     cnt_d;
    logic [31:0]            scratch_q, scratch_d;
    logic [32*NUM_CTRL-1:0] ctrl_q,    ctrl_d;
    logic [NUM_CTRL-1:0]    ctrl_wr_q, ctrl_wr_d;
    logic [32*NUM_STAT-1:0] stat_q,    stat_d;

    logic                   w_start;
    logic                   w_wr_hit;
    logic [7:0]             w_adr;
    logic [31:0]            w_rdata;
    logic [32*NUM_STAT-1:0] w_clr;

    assign w_adr    = adr_i[7:0];
    // No access may start while the previous one is being acknowledged.
    assign w_start  = en_i & ~ack_q;
    assign w_wr_hit = w_start & wr_i;

    generate
        if (ADR_WIDTH > 8) begin : g_adr_hi
            logic unused_adr_hi;
            assign unused_adr_hi = ^adr_i[ADR_WIDTH-1:8];
        end
    endgenerate

    always_comb begin
        w_rdata = UNMAPPED_VALUE;
        case (w_adr)
            8'h00:   w_rdata = IDENT;
            8'h01:   w_rdata = DATEVERSION;
            8'h02:   w_rdata = scratch_q;
            8'h03:   w_rdata = cnt_q;
            default: w_rdata = UNMAPPED_VALUE;
        endcase
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_adr == 8'(16 + i)) w_rdata = ctrl_q[32*i +: 32];
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (w_adr == 8'(32 + i)) w_rdata = stat_q[32*i +: 32];
        end
    end

    always_comb begin
        ack_d     = w_start;
        dat_d     = w_start ? w_rdata : dat_q;
        cnt_d     = w_start ? cnt_q + 32'd1 : cnt_q;
        scratch_d = (w_wr_hit && w_adr == 8'h02) ? dat_i : scratch_q;

        // Pulse bits live for exactly one cycle after being written.
        ctrl_d    = ctrl_q & ~PULSE_MASK;
        ctrl_wr_d = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_wr_hit && w_adr == 8'(16 + i)) begin
                ctrl_d[32*i +: 32] = dat_i;
                ctrl_wr_d[i]       = 1'b1;
            end
        end

        w_clr = '0;
        for (int i = 0; i < NUM_STAT; i++) begin
            if (w_wr_hit && w_adr == 8'(32 + i)) w_clr[32*i +: 32] = dat_i;
        end
        // Sticky set is OR'd after the clear so a simultaneous set wins.
        stat_d = (stat_i & ~STICKY_MASK)
               | (STICKY_MASK & (stat_i | (stat_q & ~w_clr)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            ctrl_q    <= CTRL_RESET;
            ctrl_wr_q <= '0;
            stat_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            stat_q    <= stat_d;
        end
    end

    // Reset in the acknowledge cycle suppresses the acknowledge immediately.
    assign ack_o     = ack_q & ~rst;
    assign dat_o     = dat_q;
    assign ctrl_o    = ctrl_q;
    assign ctrl_wr_o = ctrl_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_turf_register_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_turf_register_bank
// Brief   : Directed self-checking bench for turf_register_bank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_turf_register_bank;

    localparam logic [31:0]  C_IDENT  = 32'h54555246;
    localparam logic [31:0]  C_DATEV  = 32'h20240101;
    localparam logic [127:0] C_CRST   = {32'h0, 32'h0, 32'h0, 32'h12345678};
    localparam logic [127:0] C_PULSE  = 128'h1 << 64;
    localparam logic [127:0] C_STICKY = 128'h1 << 35;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en_i = 1'b0;
    logic         wr_i = 1'b0;
    logic         ack_o;
    logic [27:0]  adr_i = '0;
    logic [31:0]  dat_i = '0;
    logic [31:0]  dat_o;
    logic [127:0] ctrl_o;
    logic [3:0]   ctrl_wr_o;
    logic [127:0] stat_i = '0;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [31:0]  exp_cnt = '0;
    logic [127:0] exp_ctrl;

    turf_register_bank #(
        .NUM_CTRL(4), .NUM_STAT(4), .ADR_WIDTH(28),
        .IDENT(C_IDENT), .DATEVERSION(C_DATEV),
        .CTRL_RESET(C_CRST), .PULSE_MASK(C_PULSE), .STICKY_MASK(C_STICKY),
        .UNMAPPED_VALUE(32'hBAADF00D)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .wr_i(wr_i), .ack_o(ack_o),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ctrl_o(ctrl_o),
        .ctrl_wr_o(ctrl_wr_o), .stat_i(stat_i)
    );

    always #5 clk = ~clk;

    // One bus access; returns at the negedge of the expected ack cycle.
    task automatic access(input logic w, input logic [27:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic ak);
        @(negedge clk);
        en_i = 1'b1; wr_i = w; adr_i = a; dat_i = d;
        @(negedge clk);
        ak = ack_o; rd = dat_o;
        en_i = 1'b0; wr_i = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (ack_o !== 1'b0 || dat_o !== 32'h0 || ctrl_wr_o !== 4'h0) begin
            $display("FAIL reset_outs: ack=%b dat=%h wr=%b want 0/0/0", ack_o, dat_o, ctrl_wr_o);
        end else n_pass++;
        n_total++;
        if (ctrl_o !== C_CRST) $display("FAIL reset_ctrl: got %h want %h", ctrl_o, C_CRST);
        else n_pass++;
        rst = 1'b0;
        exp_cnt = '0;
        exp_ctrl = C_CRST;
    endtask

    task automatic test_ident();
        logic [31:0] rd; logic ak;
        logic [31:0] exp_v [3];
        logic [7:0]  adrs [3];
        adrs[0] = 8'h00; adrs[1] = 8'h01; adrs[2] = 8'h03;
        exp_v[0] = C_IDENT; exp_v[1] = C_DATEV; exp_v[2] = 32'h2;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, {20'h0, adrs[i]}, 32'h0, rd, ak);
            n_total++;
            if (ak !== 1'b1 || rd !== exp_v[i])
                $display("FAIL ident_rd%0d: ack=%b dat=%h want 1/%h", i, ak, rd, exp_v[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (ack_o !== 1'b0 || dat_o !== 32'h2)
            $display("FAIL dat_hold: ack=%b dat=%h want 0/00000002", ack_o, dat_o);
        else n_pass++;
    endtask

    task automatic test_ctrl();
        logic [31:0] rd; logic ak;
        access(1'b1, 28'h12, 32'hA5A5_0001, rd, ak);
        exp_ctrl[95:64] = 32'hA5A5_0001;
        n_total++;
        if (ak !== 1'b1 || rd !== 32'h0 || ctrl_o !== exp_ctrl || ctrl_wr_o !== 4'b0100)
            $display("FAIL ctrl_wr: ack=%b pre=%h ctrl=%h wr=%b want 1/0/%h/0100",
                     ak, rd, ctrl_o, ctrl_wr_o, exp_ctrl);
        else n_pass++;
        @(negedge clk);
        exp_ctrl[95:64] = 32'hA5A5_0000;
        n_total++;
        if (ctrl_o !== exp_ctrl || ctrl_wr_o !== 4'b0000)
            $display("FAIL ctrl_pulse: ctrl=%h wr=%b want %h/0000", ctrl_o, ctrl_wr_o, exp_ctrl);
        else n_pass++;
        access(1'b0, 28'h12, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'hA5A5_0000) $display("FAIL ctrl_rd: got %h want a5a50000", rd);
        else n_pass++;
        access(1'b1, 28'h10, 32'hCAFE_F00D, rd, ak);
        exp_ctrl[31:0] = 32'hCAFE_F00D;
        n_total++;
        if (rd !== 32'h1234_5678 || ctrl_wr_o !== 4'b0001 || ctrl_o !== exp_ctrl)
            $display("FAIL ctrl0_wr: pre=%h wr=%b ctrl=%h want 12345678/0001/%h",
                     rd, ctrl_wr_o, ctrl_o, exp_ctrl);
        else n_pass++;
        access(1'b1, 28'h02, 32'hDEAD_BEEF, rd, ak);
        access(1'b0, 28'hABCDE02, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL scratch: got %h want deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_status();
        logic [31:0] rd; logic ak;
        @(negedge clk); stat_i[35] = 1'b1;
        @(negedge clk); stat_i[35] = 1'b0;
        access(1'b0, 28'h21, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'h8) $display("FAIL sticky_set: got %h want 00000008", rd);
        else n_pass++;
        access(1'b1, 28'h21, 32'h8, rd, ak);
        access(1'b0, 28'h21, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'h0) $display("FAIL sticky_clr: got %h want 00000000", rd);
        else n_pass++;
        @(negedge clk); stat_i[35] = 1'b1;
        @(negedge clk); stat_i[35] = 1'b0;
        stat_i[35] = 1'b1;
        access(1'b1, 28'h21, 32'h8, rd, ak);
        stat_i[35] = 1'b0;
        access(1'b0, 28'h21, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'h8) $display("FAIL sticky_setwins: got %h want 00000008", rd);
        else n_pass++;
        stat_i[69] = 1'b1;
        repeat (2) @(negedge clk);
        access(1'b1, 28'h22, 32'hFFFF_FFFF, rd, ak);
        access(1'b0, 28'h22, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'h20) $display("FAIL live_stat: got %h want 00000020", rd);
        else n_pass++;
        stat_i[69] = 1'b0;
        @(negedge clk);
        access(1'b0, 28'h22, 32'h0, rd, ak);
        n_total++;
        if (rd !== 32'h0) $display("FAIL live_stat_fall: got %h want 00000000", rd);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic ak; logic [31:0] c0;
        c0 = exp_cnt;
        access(1'b0, 28'h7F, 32'h0, rd, ak);
        n_total++;
        if (ak !== 1'b1 || rd !== 32'hBAADF00D)
            $display("FAIL unmapped_rd: ack=%b dat=%h want 1/baadf00d", ak, rd);
        else n_pass++;
        access(1'b1, 28'h7F, 32'h1111_1111, rd, ak);
        n_total++;
        if (ak !== 1'b1 || ctrl_o !== exp_ctrl || ctrl_wr_o !== 4'h0)
            $display("FAIL unmapped_wr: ack=%b ctrl=%h wr=%b want 1/%h/0000",
                     ak, ctrl_o, ctrl_wr_o, exp_ctrl);
        else n_pass++;
        access(1'b1, 28'h00, 32'h1111_1111, rd, ak);
        access(1'b0, 28'h00, 32'h0, rd, ak);
        n_total++;
        if (rd !== C_IDENT) $display("FAIL ro_write: got %h want %h", rd, C_IDENT);
        else n_pass++;
        access(1'b0, 28'h03, 32'h0, rd, ak);
        n_total++;
        if (rd !== c0 + 32'd4) $display("FAIL access_cnt: got %h want %h", rd, c0 + 32'd4);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ak; int acks;
        acks = 0;
        @(negedge clk);
        en_i = 1'b1; wr_i = 1'b0; adr_i = 28'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_total++;
            if (ack_o !== 1'(k % 2))
                $display("FAIL b2b_cycle%0d: ack=%b want %b", k, ack_o, 1'(k % 2));
            else n_pass++;
            if (ack_o === 1'b1) acks++;
        end
        en_i = 1'b0;
        exp_cnt = exp_cnt + 32'd5;
        n_total++;
        if (acks != 5) $display("FAIL b2b_count: got %0d want 5", acks);
        else n_pass++;
        access(1'b0, 28'h03, 32'h0, rd, ak);
        n_total++;
        if (rd !== exp_cnt - 32'd1) $display("FAIL b2b_cnt: got %h want %h", rd, exp_cnt - 32'd1);
        else n_pass++;
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] rd; logic ak;
        @(negedge clk);
        en_i = 1'b1; wr_i = 1'b1; adr_i = 28'h10; dat_i = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b1; en_i = 1'b0; wr_i = 1'b0;
        #1;
        n_total++;
        if (ack_o !== 1'b0) $display("FAIL rst_ack: ack=%b want 0", ack_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        n_total++;
        if (ctrl_o !== C_CRST || ack_o !== 1'b0)
            $display("FAIL rst_ctrl: ctrl=%h ack=%b want %h/0", ctrl_o, ack_o, C_CRST);
        else n_pass++;
        access(1'b0, 28'h03, 32'h0, rd, ak);
        n_total++;
        if (ak !== 1'b1 || rd !== 32'h0) $display("FAIL rst_cnt: ack=%b got %h want 1/0", ak, rd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ident();
        test_ctrl();
        test_status();
        test_unmapped();
        test_back_to_back();
        test_reset_in_ack();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
